// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file master:
//   - default widths/depth used as parameter defaults by regfile_master and
//     regfile_wbuf
//   - the read-response FSM state type
// No ports (package).
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DATA_W_DEFAULT     = 32;
    localparam int ADDR_W_DEFAULT     = 5;
    localparam int WBUF_DEPTH_DEFAULT = 4;

    // Response holding register: EMPTY has no response, FULL presents one.
    typedef enum logic [0:0] {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

endpackage : regfile_pkg

// File: rtl/regfile_wbuf.sv
// -----------------------------------------------------------------------------
// regfile_wbuf
// Write buffer: a FIFO of {address, data} entries with wrapping head/tail
// pointers, plus two parallel address-search ports that return the data of
// the youngest valid entry matching each search address.
// Ports:
//   clock, ctrl_reset_n        clock / async active-low reset
//   push, push_addr, push_data enqueue an entry (caller guarantees not full)
//   pop                        dequeue the head entry (caller guarantees not empty)
//   head_addr, head_data       current head entry
//   count                      occupancy, 0..DEPTH
//   search_addr_a/b            search addresses
//   hit_a/b, hit_data_a/b      match flag and youngest matching data
// -----------------------------------------------------------------------------
module regfile_wbuf
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int ADDR_W  = ADDR_W_DEFAULT,
    parameter int DEPTH   = WBUF_DEPTH_DEFAULT,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clock,
    input  logic              ctrl_reset_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    input  logic [ADDR_W-1:0] search_addr_a,
    input  logic [ADDR_W-1:0] search_addr_b,
    output logic              hit_a,
    output logic              hit_b,
    output logic [DATA_W-1:0] hit_data_a,
    output logic [DATA_W-1:0] hit_data_b
);

    logic [ADDR_W-1:0] addr_mem_r [DEPTH];
    logic [DATA_W-1:0] data_mem_r [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;

    // Storage index of the i-th oldest entry, and whether that slot is occupied.
    logic [PTR_W-1:0]  age_idx_s [DEPTH];
    logic [DEPTH-1:0]  age_valid_s;

    // FIFO storage, pointers and occupancy counter.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_r[i] <= '0;
                data_mem_r[i] <= '0;
            end
        end else begin
            if (push) begin
                addr_mem_r[tail_r] <= push_addr;
                data_mem_r[tail_r] <= push_data;
                tail_r             <= tail_r + PTR_W'(1);
            end
            if (pop) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Map age order (0 = oldest) onto storage slots; pointer wrap is free.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_idx_s[i]   = head_r + PTR_W'(i);
            age_valid_s[i] = (CNT_W'(i) < count_r);
        end
    end

    // Youngest-match search: scanning oldest to youngest lets later hits override.
    always_comb begin
        hit_a      = 1'b0;
        hit_b      = 1'b0;
        hit_data_a = '0;
        hit_data_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_data_a = (age_valid_s[i] && (addr_mem_r[age_idx_s[i]] == search_addr_a))
                         ? data_mem_r[age_idx_s[i]] : hit_data_a;
            hit_a      = (age_valid_s[i] && (addr_mem_r[age_idx_s[i]] == search_addr_a))
                         ? 1'b1 : hit_a;
            hit_data_b = (age_valid_s[i] && (addr_mem_r[age_idx_s[i]] == search_addr_b))
                         ? data_mem_r[age_idx_s[i]] : hit_data_b;
            hit_b      = (age_valid_s[i] && (addr_mem_r[age_idx_s[i]] == search_addr_b))
                         ? 1'b1 : hit_b;
        end
    end

    assign head_addr = addr_mem_r[head_r];
    assign head_data = data_mem_r[head_r];
    assign count     = count_r;

endmodule : regfile_wbuf

// File: rtl/regfile_master.sv
// -----------------------------------------------------------------------------
// regfile_master
// Front end of a register file: buffers writes and drains them to the
// register-file write port, serves two-operand reads with write-buffer bypass
// and a one-deep registered response.
// Ports:
//   clock, ctrl_reset_n                 clock / async active-low reset
//   wr_valid/wr_ready, wr_addr/wr_data  write requests
//   rd_valid/rd_ready, rd_addrA/B       read requests
//   rsp_valid/rsp_ready, rsp_dataA/B    read responses (latency 1)
//   ctrl_hold                           stalls draining of buffered writes
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg  register-file write port
//   ctrl_readRegA/B, data_readRegA/B    register-file read port (combinational)
//   wbuf_count                          write-buffer occupancy
// -----------------------------------------------------------------------------
module regfile_master
    import regfile_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int WBUF_DEPTH = WBUF_DEPTH_DEFAULT,
    localparam int CNT_W     = $clog2(WBUF_DEPTH) + 1
) (
    input  logic              clock,
    input  logic              ctrl_reset_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addrA,
    input  logic [ADDR_W-1:0] rd_addrB,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_dataA,
    output logic [DATA_W-1:0] rsp_dataB,
    input  logic              ctrl_hold,
    output logic              ctrl_writeEnable,
    output logic [ADDR_W-1:0] ctrl_writeReg,
    output logic [DATA_W-1:0] data_writeReg,
    output logic [ADDR_W-1:0] ctrl_readRegA,
    output logic [ADDR_W-1:0] ctrl_readRegB,
    input  logic [DATA_W-1:0] data_readRegA,
    input  logic [DATA_W-1:0] data_readRegB,
    output logic [CNT_W-1:0]  wbuf_count
);

    logic [CNT_W-1:0]  count_s;
    logic              push_s;
    logic              pop_s;
    logic [ADDR_W-1:0] head_addr_s;
    logic [DATA_W-1:0] head_data_s;
    logic              hit_a_s;
    logic              hit_b_s;
    logic [DATA_W-1:0] hit_data_a_s;
    logic [DATA_W-1:0] hit_data_b_s;
    logic              rd_accept_s;
    logic [DATA_W-1:0] resolved_a_s;
    logic [DATA_W-1:0] resolved_b_s;
    rsp_state_e        state_r;
    rsp_state_e        state_next_s;
    logic [DATA_W-1:0] rsp_a_r;
    logic [DATA_W-1:0] rsp_b_r;

    // Write side: ready depends only on occupancy, never on a same-cycle drain.
    assign wr_ready = (count_s < CNT_W'(WBUF_DEPTH));
    assign push_s   = wr_valid && wr_ready;
    assign pop_s    = (count_s != '0) && !ctrl_hold;

    // Head entry is presented only while it is being popped; r0 entries drain silently.
    assign ctrl_writeEnable = pop_s && (head_addr_s != '0);
    assign ctrl_writeReg    = pop_s ? head_addr_s : '0;
    assign data_writeReg    = pop_s ? head_data_s : '0;
    assign wbuf_count       = count_s;

    // Read side.
    assign ctrl_readRegA = rd_addrA;
    assign ctrl_readRegB = rd_addrB;
    assign rsp_valid     = (state_r == RSP_FULL);
    assign rd_ready      = !rsp_valid || rsp_ready;
    assign rd_accept_s   = rd_valid && rd_ready;
    assign rsp_dataA     = rsp_a_r;
    assign rsp_dataB     = rsp_b_r;

    regfile_wbuf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (WBUF_DEPTH)
    ) u_wbuf (
        .clock         (clock),
        .ctrl_reset_n  (ctrl_reset_n),
        .push          (push_s),
        .push_addr     (wr_addr),
        .push_data     (wr_data),
        .pop           (pop_s),
        .head_addr     (head_addr_s),
        .head_data     (head_data_s),
        .count         (count_s),
        .search_addr_a (rd_addrA),
        .search_addr_b (rd_addrB),
        .hit_a         (hit_a_s),
        .hit_b         (hit_b_s),
        .hit_data_a    (hit_data_a_s),
        .hit_data_b    (hit_data_b_s)
    );

    // Operand A: r0 is hard zero, otherwise buffered data wins over the register file.
    always_comb begin
        resolved_a_s = '0;
        if (rd_addrA == '0) begin
            resolved_a_s = '0;
        end else if (hit_a_s) begin
            resolved_a_s = hit_data_a_s;
        end else begin
            resolved_a_s = data_readRegA;
        end
    end

    // Operand B: resolved independently of A.
    always_comb begin
        resolved_b_s = '0;
        if (rd_addrB == '0) begin
            resolved_b_s = '0;
        end else if (hit_b_s) begin
            resolved_b_s = hit_data_b_s;
        end else begin
            resolved_b_s = data_readRegB;
        end
    end

    // Response FSM state register.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_r <= RSP_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Response FSM next state.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            RSP_EMPTY: begin
                if (rd_accept_s) begin
                    state_next_s = RSP_FULL;
                end else begin
                    state_next_s = RSP_EMPTY;
                end
            end
            RSP_FULL: begin
                if (rsp_ready && !rd_accept_s) begin
                    state_next_s = RSP_EMPTY;
                end else begin
                    state_next_s = RSP_FULL;
                end
            end
            default: state_next_s = RSP_EMPTY;
        endcase
    end

    // Response data: captured on accept, otherwise held (stable under backpressure).
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            rsp_a_r <= '0;
            rsp_b_r <= '0;
        end else if (rd_accept_s) begin
            rsp_a_r <= resolved_a_s;
            rsp_b_r <= resolved_b_s;
        end else begin
            rsp_a_r <= rsp_a_r;
            rsp_b_r <= rsp_b_r;
        end
    end

endmodule : regfile_master

// File: tb/tb_regfile_master.sv
// -----------------------------------------------------------------------------
// tb_regfile_master
// Self-checking bench: a directed vector table, hand-written backpressure and
// reset sequences, and a randomized phase, all scored against a transaction
// model (queue of pending writes + shadow register array).
// -----------------------------------------------------------------------------
module tb_regfile_master;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clock;
    logic          ctrl_reset_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addrA;
    logic [AW-1:0] rd_addrB;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_dataA;
    logic [DW-1:0] rsp_dataB;
    logic          ctrl_hold;
    logic          ctrl_writeEnable;
    logic [AW-1:0] ctrl_writeReg;
    logic [DW-1:0] data_writeReg;
    logic [AW-1:0] ctrl_readRegA;
    logic [AW-1:0] ctrl_readRegB;
    logic [DW-1:0] data_readRegA;
    logic [DW-1:0] data_readRegB;
    logic [CW-1:0] wbuf_count;

    regfile_master dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .rd_addrA         (rd_addrA),
        .rd_addrB         (rd_addrB),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_dataA        (rsp_dataA),
        .rsp_dataB        (rsp_dataB),
        .ctrl_hold        (ctrl_hold),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .wbuf_count       (wbuf_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Environment register file, written only through the DUT's write port.
    logic [DW-1:0] rf [32];
    logic          load_rf;

    function automatic logic [31:0] init_val(input int i);
        return 32'hC0DE_0000 | (32'(i) * 32'h0000_0101);
    endfunction

    always @(posedge clock) begin
        if (load_rf) begin
            for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
        end else if (ctrl_writeEnable) begin
            rf[ctrl_writeReg] <= data_writeReg;
        end
    end

    assign data_readRegA = rf[ctrl_readRegA];
    assign data_readRegB = rf[ctrl_readRegB];

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           wq[$];
    logic [DW-1:0] mregs [32];
    bit            m_rv;
    logic [DW-1:0] m_a;
    logic [DW-1:0] m_b;

    int vectors;
    int miscompares;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Value a read of addr would return against the current pending-write queue.
    function automatic logic [31:0] resolve(input logic [AW-1:0] addr);
        if (addr == 5'd0) return 32'd0;
        for (int i = wq.size() - 1; i >= 0; i--) begin
            if (wq[i].addr == addr) return wq[i].data;
        end
        return mregs[addr];
    endfunction

    task automatic model_check();
        bit exp_pop;
        exp_pop = (wq.size() > 0) && !ctrl_hold;
        chk("wbuf_count", 32'(wbuf_count), 32'(wq.size()));
        chk("wr_ready", 32'(wr_ready), 32'(wq.size() < DEPTH));
        chk("rd_ready", 32'(rd_ready), 32'(!m_rv || rsp_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        chk("readRegA", 32'(ctrl_readRegA), 32'(rd_addrA));
        chk("readRegB", 32'(ctrl_readRegB), 32'(rd_addrB));
        if (exp_pop) begin
            chk("writeEnable", 32'(ctrl_writeEnable), 32'(wq[0].addr != 5'd0));
            chk("writeReg", 32'(ctrl_writeReg), 32'(wq[0].addr));
            chk("data_writeReg", data_writeReg, wq[0].data);
        end else begin
            chk("writeEnable", 32'(ctrl_writeEnable), 32'd0);
        end
        if (m_rv) begin
            chk("rsp_dataA", rsp_dataA, m_a);
            chk("rsp_dataB", rsp_dataB, m_b);
        end
    endtask

    task automatic model_edge();
        bit            pop, wacc, racc;
        logic [DW-1:0] ra, rb;
        wr_t           h;
        pop  = (wq.size() > 0) && !ctrl_hold;
        wacc = wr_valid && (wq.size() < DEPTH);
        racc = rd_valid && (!m_rv || rsp_ready);
        ra   = resolve(rd_addrA);
        rb   = resolve(rd_addrB);
        if (pop) begin
            h = wq.pop_front();
            if (h.addr != 5'd0) mregs[h.addr] = h.data;
        end
        if (wacc) wq.push_back('{addr: wr_addr, data: wr_data});
        if (racc) begin
            m_rv = 1'b1;
            m_a  = ra;
            m_b  = rb;
        end else if (rsp_ready) begin
            m_rv = 1'b0;
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        model_check();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic idle();
        ctrl_hold = 1'b0;
        wr_valid  = 1'b0;
        wr_addr   = 5'd0;
        wr_data   = 32'd0;
        rd_valid  = 1'b0;
        rd_addrA  = 5'd0;
        rd_addrB  = 5'd0;
        rsp_ready = 1'b1;
    endtask

    task automatic check_reset_state();
        chk("rst wbuf_count", 32'(wbuf_count), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_dataA", rsp_dataA, 32'd0);
        chk("rst rsp_dataB", rsp_dataB, 32'd0);
        chk("rst writeEnable", 32'(ctrl_writeEnable), 32'd0);
        chk("rst writeReg", 32'(ctrl_writeReg), 32'd0);
        chk("rst data_writeReg", data_writeReg, 32'd0);
        chk("rst wr_ready", 32'(wr_ready), 32'd1);
        chk("rst rd_ready", 32'(rd_ready), 32'd1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit            hold;
        bit            wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        bit            rv;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic [CW-1:0] ex_cnt;
        bit            ex_wrdy;
        bit            ex_we;
        bit            ex_rsp;
    } vec_t;

    localparam int NVEC = 25;
    vec_t tbl [NVEC];

    initial begin
        vectors     = 0;
        miscompares = 0;
        idle();
        ctrl_reset_n = 1'b0;
        load_rf      = 1'b1;
        for (int i = 0; i < 32; i++) mregs[i] = init_val(i);
        m_rv = 1'b0;
        m_a  = 32'd0;
        m_b  = 32'd0;

        //          hold wv  wa     wd             rv  ra     rb     cnt   wrdy we  rsp
        tbl[0]  = '{1'b1, 1'b1, 5'd3, 32'h0000_000A, 1'b0, 5'd0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 5'd3, 32'h0000_000B, 1'b0, 5'd0, 5'd0, 3'd1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 5'd0, 32'h0,         1'b1, 5'd3, 5'd3, 3'd2, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 3'd2, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 3'd2, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 3'd1, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 5'd1, 32'h0000_0011, 1'b0, 5'd0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 5'd2, 32'h0000_0022, 1'b0, 5'd0, 5'd0, 3'd1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 5'd4, 32'h0000_0044, 1'b0, 5'd0, 5'd0, 3'd2, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 5'd6, 32'h0000_0066, 1'b0, 5'd0, 5'd0, 3'd3, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 5'd7, 32'h0000_0077, 1'b0, 5'd0, 5'd0, 3'd4, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 5'd7, 32'h0000_0077, 1'b0, 5'd0, 5'd0, 3'd4, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 5'd7, 32'h0000_0077, 1'b0, 5'd0, 5'd0, 3'd3, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 3'd3, 1'b1, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 3'd2, 1'b1, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 3'd1, 1'b1, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 5'd0, 3'd1, 1'b1, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b1};
        tbl[21] = '{1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 3'd1, 1'b1, 1'b1, 1'b0};
        tbl[23] = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 5'd5, 5'd5, 3'd0, 1'b1, 1'b0, 1'b0};
        tbl[24] = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b1};

        // ---- power-on reset ----
        @(posedge clock);
        #1;
        load_rf = 1'b0;
        check_reset_state();
        @(negedge clock);
        #1;
        ctrl_reset_n = 1'b1;
        @(posedge clock);
        model_edge();
        #1;

        // ---- table ----
        for (int r = 0; r < NVEC; r++) begin
            ctrl_hold = tbl[r].hold;
            wr_valid  = tbl[r].wv;
            wr_addr   = tbl[r].wa;
            wr_data   = tbl[r].wd;
            rd_valid  = tbl[r].rv;
            rd_addrA  = tbl[r].ra;
            rd_addrB  = tbl[r].rb;
            rsp_ready = 1'b1;
            @(negedge clock);
            model_check();
            chk($sformatf("tbl[%0d] wbuf_count", r), 32'(wbuf_count), 32'(tbl[r].ex_cnt));
            chk($sformatf("tbl[%0d] wr_ready", r), 32'(wr_ready), 32'(tbl[r].ex_wrdy));
            chk($sformatf("tbl[%0d] writeEnable", r), 32'(ctrl_writeEnable), 32'(tbl[r].ex_we));
            chk($sformatf("tbl[%0d] rsp_valid", r), 32'(rsp_valid), 32'(tbl[r].ex_rsp));
            if (r == 3) begin
                chk("bypass youngest A", rsp_dataA, 32'h0000_000B);
                chk("bypass youngest B", rsp_dataB, 32'h0000_000B);
            end
            if (r == 20) chk("r0 read", rsp_dataA, 32'd0);
            if (r == 24) chk("r5 read", rsp_dataA, 32'hDEAD_BEEF);
            @(posedge clock);
            model_edge();
            #1;
        end
        idle();

        // ---- response backpressure, then back-to-back ----
        rd_valid  = 1'b1;
        rd_addrA  = 5'd5;
        rd_addrB  = 5'd1;
        rsp_ready = 1'b0;
        cycle();
        rd_addrA = 5'd2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            model_check();
            chk("stall rd_ready", 32'(rd_ready), 32'd0);
            chk("stall rsp_dataA", rsp_dataA, 32'hDEAD_BEEF);
            chk("stall rsp_dataB", rsp_dataB, 32'h0000_0011);
            @(posedge clock);
            model_edge();
            #1;
        end
        rsp_ready = 1'b1;
        cycle();
        rd_valid = 1'b0;
        @(negedge clock);
        model_check();
        chk("b2b rsp_valid", 32'(rsp_valid), 32'd1);
        chk("b2b rsp_dataA", rsp_dataA, 32'h0000_0022);
        @(posedge clock);
        model_edge();
        #1;
        idle();

        // ---- reset with buffered writes and a pending response ----
        ctrl_hold = 1'b1;
        wr_valid  = 1'b1;
        wr_addr   = 5'd10;
        wr_data   = 32'hAAAA_0010;
        rd_valid  = 1'b1;
        rd_addrA  = 5'd10;
        rd_addrB  = 5'd12;
        rsp_ready = 1'b0;
        cycle();
        rd_valid = 1'b0;
        wr_addr  = 5'd11;
        wr_data  = 32'hAAAA_0011;
        cycle();
        wr_addr = 5'd12;
        wr_data = 32'hAAAA_0012;
        cycle();
        chk("pre-reset wbuf_count", 32'(wbuf_count), 32'd3);
        chk("pre-reset rsp_valid", 32'(rsp_valid), 32'd1);
        chk("pre-reset rsp_dataA", rsp_dataA, init_val(10));
        ctrl_reset_n = 1'b0;
        #1;
        check_reset_state();
        wq.delete();
        m_rv = 1'b0;
        m_a  = 32'd0;
        m_b  = 32'd0;
        @(negedge clock);
        #1;
        ctrl_reset_n = 1'b1;
        ctrl_hold    = 1'b0;
        wr_valid     = 1'b1;
        wr_addr      = 5'd13;
        wr_data      = 32'h1313_1313;
        rd_valid     = 1'b1;
        rd_addrA     = 5'd10;
        rd_addrB     = 5'd11;
        rsp_ready    = 1'b1;
        @(posedge clock);
        model_edge();
        #1;
        idle();
        @(negedge clock);
        model_check();
        chk("post-reset wbuf_count", 32'(wbuf_count), 32'd1);
        chk("post-reset rsp_valid", 32'(rsp_valid), 32'd1);
        chk("post-reset rsp_dataA", rsp_dataA, init_val(10));
        chk("post-reset rsp_dataB", rsp_dataB, init_val(11));
        @(posedge clock);
        model_edge();
        #1;

        // ---- randomized traffic ----
        for (int n = 0; n < 400; n++) begin
            ctrl_hold = ($urandom_range(0, 3) == 0);
            wr_valid  = 1'($urandom_range(0, 1));
            wr_addr   = 5'($urandom_range(0, 7));
            wr_data   = $urandom;
            rd_valid  = 1'($urandom_range(0, 1));
            rd_addrA  = 5'($urandom_range(0, 7));
            rd_addrB  = ($urandom_range(0, 3) == 0) ? rd_addrA : 5'($urandom_range(0, 7));
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_regfile_master

// File: doc/regfile_master.md
REGFILE_MASTER -- requirements
Module: regfile_master

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, register index width (32 registers).
REQ-003 Parameter WBUF_DEPTH, default 4, write-buffer entries (power of two).
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 ctrl_reset_n  in  1  reset, asynchronous, active-low.
REQ-006 wr_valid / wr_ready  in / out  1 / 1  write-request handshake.
REQ-007 wr_addr / wr_data  in  ADDR_W / DATA_W  write-request target and value.
REQ-008 rd_valid / rd_ready  in / out  1 / 1  read-request handshake.
REQ-009 rd_addrA / rd_addrB  in  ADDR_W  read-request operand indices.
REQ-010 rsp_valid / rsp_ready  out / in  1 / 1  read-response handshake.
REQ-011 rsp_dataA / rsp_dataB  out  DATA_W  read-response operands.
REQ-012 ctrl_hold  in  1  while high, buffered writes are not drained to the register file.
REQ-013 ctrl_writeEnable, ctrl_writeReg, data_writeReg  out  1, ADDR_W, DATA_W  register-file write port.
REQ-014 ctrl_readRegA, ctrl_readRegB  out  ADDR_W  register-file read indices.
REQ-015 data_readRegA, data_readRegB  in  DATA_W  register-file read data (combinational, same cycle).
REQ-016 wbuf_count  out  clog2(WBUF_DEPTH)+1  current write-buffer occupancy.

Function
REQ-017 A write SHALL be accepted on an edge where wr_valid and wr_ready are both high; wr_ready = (wbuf_count < WBUF_DEPTH), independent of drain in the same cycle.
REQ-018 Accepted writes SHALL enter a FIFO with wrapping head/tail pointers; the count SHALL increment on push, decrement on pop, and stay unchanged on a simultaneous push and pop.
REQ-019 When the buffer is non-empty and ctrl_hold is low, the head entry SHALL be driven on ctrl_writeReg/data_writeReg and popped at that edge.
REQ-020 ctrl_writeEnable SHALL be high exactly when REQ-019 pops a head entry whose address is nonzero.
REQ-021 A popped entry addressed to register 0 SHALL be discarded with ctrl_writeEnable low.
REQ-022 A read SHALL be accepted on an edge where rd_valid and rd_ready are both high; rd_ready = !rsp_valid || rsp_ready.
REQ-023 ctrl_readRegA/B SHALL equal rd_addrA/B combinationally.
REQ-024 rsp_dataA/B SHALL be captured at the accepting edge, and rsp_valid SHALL rise the following cycle (latency 1).
REQ-025 Bypass: if any valid buffer entry, including the head being popped that cycle, matches the read address, the data of the youngest matching entry SHALL be returned instead of data_readRegX.
REQ-026 A write accepted at the same edge as a read SHALL NOT be visible to that read (read-before-write ordering).
REQ-027 A read of register 0 SHALL return 0 regardless of buffer contents or data_readRegX.
REQ-028 The response FSM SHALL have two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-029 EMPTY SHALL go to FULL on a read accept.
REQ-030 FULL SHALL stay FULL on rsp_ready with a new accept, go to EMPTY on rsp_ready without an accept, and hold rsp_data stable while rsp_ready is low.
REQ-031 Operands A and B SHALL be resolved independently, and A may equal B.

Reset
REQ-032 Asserting ctrl_reset_n low SHALL immediately empty the buffer, zero both pointers and wbuf_count, and discard pending writes.
REQ-033 During reset, rsp_valid=0, rsp_dataA/B=0, ctrl_writeEnable=0, ctrl_writeReg=0 and data_writeReg=0.
REQ-034 wr_ready SHALL be 1 during reset; rd_ready SHALL be 1 during reset.
REQ-035 The first accept SHALL occur at the first rising edge after deassertion.

Structure
REQ-036 Package regfile_pkg SHALL hold DATA_W, ADDR_W, WBUF_DEPTH defaults and the response-FSM state enum.
REQ-037 Sub-module regfile_wbuf SHALL implement the write FIFO with its parallel youngest-match address search (two search ports); the top level SHALL hold the handshakes and the response FSM.

Verification
REQ-038 Reset; write r5=0xDEADBEEF; after drain read r5 -> rsp_dataA=0xDEADBEEF, rsp_valid exactly 1 cycle after accept.
REQ-039 ctrl_hold=1; write r3=0xA then r3=0xB; read A=r3, B=r3 -> both 0xB; release hold -> two commits in order, wbuf_count 2->0.
REQ-040 ctrl_hold=1; four writes -> wr_ready=0, fifth held off; release -> wr_ready=1 the cycle after the first pop.
REQ-041 Write r0=0xFFFFFFFF then read r0 -> ctrl_writeEnable stays 0 and rsp_dataA=0.
REQ-042 Response pending with rsp_ready=0 for 3 cycles -> rd_ready=0 and rsp_data stable; assert rsp_ready with rd_valid -> back-to-back response.
REQ-043 ctrl_reset_n low with 3 buffered writes and rsp_valid=1 -> wbuf_count=0, rsp_valid=0 immediately; later reads return original register values.
